// File: rtl/vga_fb_reader_pkg.sv
// Shared constants for the frame-buffer read path: scale encodings, pipeline
// depth, RGB332 colours and the colour-bar table.
package vga_fb_reader_pkg;

    typedef enum logic [1:0] {
        SCALE_1X   = 2'b00,
        SCALE_2X   = 2'b01,
        SCALE_4X   = 2'b10,
        SCALE_RSVD = 2'b11
    } scale_e;

    localparam int unsigned PIPE_LAT = 3;

    localparam logic [7:0] RGB_BLACK   = 8'h00;
    localparam logic [7:0] RGB_WHITE   = 8'hFF;
    localparam logic [7:0] RGB_RED     = 8'hE0;
    localparam logic [7:0] RGB_GREEN   = 8'h1C;
    localparam logic [7:0] RGB_BLUE    = 8'h03;
    localparam logic [7:0] RGB_YELLOW  = 8'hFC;
    localparam logic [7:0] RGB_CYAN    = 8'h1F;
    localparam logic [7:0] RGB_MAGENTA = 8'hE3;

    // log2 of the upscale factor; the reserved code behaves as 1x
    function automatic logic [1:0] scale_shift(input scale_e s);
        case (s)
            SCALE_2X: return 2'd1;
            SCALE_4X: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

    // Threshold compare against constant multiples of the width, so no divider
    function automatic logic [2:0] bar_index(input int unsigned col, input int unsigned cam_x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if ((col << 3) >= k * cam_x) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_fb_reader_axis_counter.sv
// Per-axis upscale counter: sub-scale counter, saturating index and a base
// accumulator stepped by STRIDE each time the sub-counter wraps.
module fb_axis_counter
    import vga_fb_reader_pkg::*;
#(
    parameter int unsigned IW      = 8,
    parameter int unsigned BW      = 8,
    parameter int unsigned SAT_MAX = 160,
    parameter int unsigned STRIDE  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          step,
    input  logic [1:0]    scale,
    output logic [BW-1:0] base
);

    logic [1:0]    sub_q, sub_cur, sub_max;
    logic [IW-1:0] idx_q, idx_cur;
    logic [BW-1:0] base_q;
    logic          wrap, saturate;

    // restart takes effect in the same cycle, so the current position already sees zero
    always_comb begin
        sub_cur = restart ? '0 : sub_q;
        idx_cur = restart ? '0 : idx_q;
        base    = restart ? '0 : base_q;
        case (scale)
            2'd1:    sub_max = 2'd1;
            2'd2:    sub_max = 2'd3;
            default: sub_max = 2'd0;
        endcase
        wrap     = step && (sub_cur == sub_max);
        saturate = (idx_cur == IW'(SAT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q  <= '0;
            idx_q  <= '0;
            base_q <= '0;
        end else begin
            sub_q  <= sub_cur;
            idx_q  <= idx_cur;
            base_q <= base;
            if (step) begin
                if (wrap) begin
                    sub_q <= '0;
                    if (!saturate) idx_q <= idx_cur + IW'(1);
                    if (idx_cur < IW'(SAT_MAX - 1)) base_q <= base + BW'(STRIDE);
                end else begin
                    sub_q <= sub_cur + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer read address generator and pixel formatter with 1x/2x/4x upscale.
// Optional colour-bar source enabled by VGA_FB_READER_TEST_PATTERN_EN.
module vga_fb_reader
    import vga_fb_reader_pkg::*;
#(
    parameter int unsigned CAM_SCREEN_X = 160,
    parameter int unsigned CAM_SCREEN_Y = 120,
    parameter int unsigned AW           = 15,
    parameter int unsigned DW           = 8,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    pos_x,
    input  logic [8:0]    pos_y,
    input  logic [1:0]    scale_sel,
    input  logic [DW-1:0] border_color,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] pixel_out,
    output logic          in_window
`ifdef VGA_FB_READER_TEST_PATTERN_EN
    ,
    input  logic          test_pattern
`endif
);

    localparam int unsigned CW = $clog2(CAM_SCREEN_X + 1);
    localparam int unsigned RW = $clog2(CAM_SCREEN_Y + 1);

    scale_e        scale_q, scale_cur;
    logic          started_q, active;
    logic          frame_start, line_start, x_in, y_in, win, row_step;
    logic          win_d1, win_d2;
    logic [1:0]    sh;
    logic [15:0]   win_w, win_h;
    logic [CW-1:0] col;
    logic [AW-1:0] row_base;
    logic [DW-1:0] src;

    // Frame start uses the incoming scale immediately so pixel (0,0) already steps at the new rate
    always_comb begin
        frame_start = (pos_x == '0) && (pos_y == '0);
        line_start  = (pos_x == '0);
        scale_cur   = frame_start ? scale_e'(scale_sel) : scale_q;
        sh          = scale_shift(scale_cur);
        win_w       = 16'(CAM_SCREEN_X) << sh;
        win_h       = 16'(CAM_SCREEN_Y) << sh;
        x_in        = {6'd0, pos_x} < win_w;
        y_in        = {7'd0, pos_y} < win_h;
        active      = started_q || frame_start;
        win         = active && x_in && y_in;
        row_step    = active && y_in && (pos_x == 10'(H_ACTIVE - 1))
                      && ({7'd0, pos_y} < 16'(V_ACTIVE));
    end

    fb_axis_counter #(
        .IW(CW), .BW(CW), .SAT_MAX(CAM_SCREEN_X), .STRIDE(1)
    ) u_x_cnt (
        .clk(clk), .rst(rst), .restart(line_start), .step(win), .scale(sh), .base(col)
    );

    fb_axis_counter #(
        .IW(RW), .BW(AW), .SAT_MAX(CAM_SCREEN_Y), .STRIDE(CAM_SCREEN_X)
    ) u_y_cnt (
        .clk(clk), .rst(rst), .restart(frame_start), .step(row_step), .scale(sh), .base(row_base)
    );

`ifdef VGA_FB_READER_TEST_PATTERN_EN
    logic       tp_q, tp_cur, tp_d1, tp_d2;
    logic [2:0] bar_d1, bar_d2;

    assign tp_cur = frame_start ? test_pattern : tp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp_q   <= 1'b0;
            tp_d1  <= 1'b0;
            tp_d2  <= 1'b0;
            bar_d1 <= '0;
            bar_d2 <= '0;
        end else begin
            if (frame_start) tp_q <= test_pattern;
            tp_d1  <= tp_cur;
            tp_d2  <= tp_d1;
            bar_d1 <= bar_index(32'(col), CAM_SCREEN_X);
            bar_d2 <= bar_d1;
        end
    end

    assign src = tp_d2 ? DW'(bar_color(bar_d2)) : mem_data;
`else
    assign src = mem_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_q   <= SCALE_1X;
            started_q <= 1'b0;
            mem_addr  <= '0;
            win_d1    <= 1'b0;
            win_d2    <= 1'b0;
            pixel_out <= '0;
            in_window <= 1'b0;
        end else begin
            if (frame_start) begin
                scale_q   <= scale_cur;
                started_q <= 1'b1;
            end
            mem_addr  <= win ? (row_base + AW'(col)) : '0;
            win_d1    <= win;
            win_d2    <= win_d1;
            pixel_out <= win_d2 ? src : border_color;
            in_window <= win_d2;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Scoreboard bench for vga_fb_reader: directed line sweeps push expected address
// and pixel entries; a monitor pops and compares them as the DUT produces them.
module tb_vga_fb_reader;
    import vga_fb_reader_pkg::*;

    localparam int CX = 160, CY = 120, AW = 15, HA = 640, VA = 480;
    localparam int NPIX = CX * CY;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    pos_x = '0;
    logic [8:0]    pos_y = '0;
    logic [1:0]    scale_sel = 2'b00;
    logic [7:0]    border_color = 8'hE0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data = 8'h00;
    logic [7:0]    pixel_out;
    logic          in_window;
`ifdef VGA_FB_READER_TEST_PATTERN_EN
    logic          test_pattern = 1'b0;
`endif

    vga_fb_reader #(
        .CAM_SCREEN_X(CX), .CAM_SCREEN_Y(CY), .AW(AW), .DW(8), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .scale_sel(scale_sel),
        .border_color(border_color), .mem_addr(mem_addr), .mem_data(mem_data),
        .pixel_out(pixel_out), .in_window(in_window)
`ifdef VGA_FB_READER_TEST_PATTERN_EN
        , .test_pattern(test_pattern)
`endif
    );

    always #20 clk = ~clk;

    logic [7:0] ram [0:NPIX-1];
    always @(posedge clk) mem_data <= (int'(mem_addr) < NPIX) ? ram[mem_addr] : 8'h00;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            x;
        int            y;
        logic [AW-1:0] addr;
        logic [7:0]    pix;
        logic          win;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];
    int   checks = 0;
    int   errors = 0;

    int m_sh = 0;
    bit m_started = 1'b0;
    bit m_tp = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                e = aq.pop_front();
                if (e.due != cyc) check($sformatf("addr_late(%0d,%0d)", e.x, e.y), 32'(e.due), 32'(cyc));
                else check($sformatf("mem_addr(%0d,%0d)", e.x, e.y), 32'(mem_addr), 32'(e.addr));
            end
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                e = pq.pop_front();
                if (e.due != cyc) begin
                    check($sformatf("pix_late(%0d,%0d)", e.x, e.y), 32'(e.due), 32'(cyc));
                end else begin
                    check($sformatf("pixel_out(%0d,%0d)", e.x, e.y), 32'(pixel_out), 32'(e.pix));
                    check($sformatf("in_window(%0d,%0d)", e.x, e.y), 32'(in_window), 32'(e.win));
                end
            end
        end
    end

    // Reference: direct division of the position by the scale factor
    task automatic drive(input int x, input int y, input bit chk_on);
        exp_t e;
        bit   w;
        int   a;
        if (x == 0 && y == 0) begin
            m_started = 1'b1;
            m_sh = (scale_sel == 2'b01) ? 1 : (scale_sel == 2'b10) ? 2 : 0;
`ifdef VGA_FB_READER_TEST_PATTERN_EN
            m_tp = test_pattern;
`endif
        end
        w = m_started && (x < (CX << m_sh)) && (y < (CY << m_sh));
        a = w ? (y >> m_sh) * CX + (x >> m_sh) : 0;
        e.x = x;
        e.y = y;
        e.addr = AW'(a);
        e.win = w;
        e.pix = w ? (m_tp ? bar_color(3'((x >> m_sh) / (CX / 8))) : ram[a]) : border_color;
        pos_x = 10'(x);
        pos_y = 9'(y);
        if (chk_on) begin
            e.due = cyc + 1;
            aq.push_back(e);
            e.due = cyc + 3;
            pq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic full_line(input int y, input int xend);
        for (int x = 0; x < xend; x++) drive(x, y, 1'b1);
        if (xend < HA) drive(HA - 1, y, 1'b1);
    endtask

    task automatic fast_line(input int y);
        drive(0, y, 1'b1);
        drive(HA - 1, y, ((HA - 1) >= (CX << m_sh)) ? 1'b1 : 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(650, 500, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) ram[i] = 8'((i * 37) ^ (i >> 5));

        repeat (3) @(posedge clk);
        #1;
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset pixel_out", 32'(pixel_out), 32'd0);
        check("reset in_window", 32'(in_window), 32'd0);
        rst = 1'b0;

        // before the first frame start: border only
        for (int i = 0; i < 6; i++) drive(10 + i, 5, 1'b1);

        // 1x frame
        scale_sel = 2'b00;
        for (int y = 0; y < 4; y++) full_line(y, 162);
        for (int y = 4; y < 122; y++) fast_line(y);

        // 2x frame
        scale_sel = 2'b01;
        for (int y = 0; y < 4; y++) full_line(y, 322);
        for (int y = 4; y < 239; y++) fast_line(y);
        full_line(239, 322);
        fast_line(240);

        idle(4);
        border_color = 8'h03;

        // 4x frame
        scale_sel = 2'b10;
        full_line(0, HA);
        for (int y = 1; y < 479; y++) fast_line(y);
        full_line(479, HA);

        // mid-frame scale change is deferred to the next frame
        scale_sel = 2'b00;
        for (int y = 0; y < 50; y++) fast_line(y);
        scale_sel = 2'b01;
        full_line(50, 162);
        for (int y = 51; y < 122; y++) fast_line(y);

        // 2x frame interrupted by reset at (80,60)
        for (int y = 0; y < 60; y++) fast_line(y);
        for (int x = 0; x <= 80; x++) drive(x, 60, 1'b1);
        rst = 1'b1;
        aq.delete();
        pq.delete();
        m_started = 1'b0;
        #1;
        check("midreset mem_addr", 32'(mem_addr), 32'd0);
        check("midreset pixel_out", 32'(pixel_out), 32'd0);
        check("midreset in_window", 32'(in_window), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int x = 81; x < 322; x++) drive(x, 60, 1'b1);
        drive(HA - 1, 60, 1'b1);
        for (int y = 61; y < 240; y++) fast_line(y);

        // 2x frame after the reset recovers fully
        full_line(0, 322);
        full_line(1, 322);
        for (int y = 2; y < 60; y++) fast_line(y);
        full_line(60, 322);

        // reserved scale code behaves as 1x
        scale_sel = 2'b11;
        full_line(0, 162);
        fast_line(1);
        full_line(2, 162);

`ifdef VGA_FB_READER_TEST_PATTERN_EN
        scale_sel = 2'b00;
        test_pattern = 1'b1;
        full_line(0, 162);
        full_line(1, 162);
        test_pattern = 1'b0;
`endif

        idle(5);
        check("scoreboard drained", 32'(aq.size() + pq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
